// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM-stage load/store unit and the data memory.
//   req    master->slave  transaction request, held for the whole transaction
//   we     master->slave  1 = write
//   addr   master->slave  word-aligned byte address (ADDR_W bits)
//   be     master->slave  byte enables, bit i = byte lane i
//   wdata  master->slave  lane-replicated store data
//   ack    slave->master  transaction complete; rdata valid in the same cycle
//   rdata  slave->master  read word
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit. Turns EX/MEM load/store controls into a req/ack data-memory
// transaction, aligns and sign/zero-extends load data onto memdata, and stalls the pipeline
// until the access has finished. Bus latency is bounded by a timeout.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned accesses (no bus transaction,
// misalign_err pulse, loads return 0). Undefined: offending low address bits are ignored.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   mem_read_ex_mem    load in MEM stage
//   mem_write_ex_mem   store in MEM stage (wins when both are set)
//   funct3_ex_mem      size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; others as word
//   alu_result_ex_mem  effective address
//   store_data_ex_mem  store source
//   dmem               data-memory bus (master side)
//   memdata            aligned/extended load result to MEM/WB
//   mem_stall          freeze upstream pipeline
//   bus_err            one-cycle pulse on timeout abort
//   misalign_err       one-cycle pulse on trapped misaligned access
module mem_access_stage #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read_ex_mem,
  input  logic                      mem_write_ex_mem,
  input  logic [2:0]                funct3_ex_mem,
  input  logic [31:0]               alu_result_ex_mem,
  input  logic [31:0]               store_data_ex_mem,
  mem_access_stage_if.master        dmem,
  output logic [31:0]               memdata,
  output logic                      mem_stall,
  output logic                      bus_err,
  output logic                      misalign_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, load_q;
  logic [3:0]        be_q, be_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q, off_n;
  logic [31:0]       memdata_q, memdata_d;
  logic              bus_err_q, bus_err_d;
  logic              access, trap, capture, stall_raw;
  logic [31:0]       shifted;
  logic [31:0]       load_val;

  assign access = mem_read_ex_mem | mem_write_ex_mem;

  // Lane decode. off_n is the effective byte offset with offending low bits forced to 0,
  // so non-trapping misaligned accesses hit the enclosing aligned half/word.
  always_comb begin
    off_n   = 2'b00;
    be_n    = 4'b1111;
    wdata_n = store_data_ex_mem;
    case (funct3_ex_mem[1:0])
      2'b00: begin
        off_n   = alu_result_ex_mem[1:0];
        be_n    = 4'b0001 << alu_result_ex_mem[1:0];
        wdata_n = {4{store_data_ex_mem[7:0]}};
      end
      2'b01: begin
        off_n   = {alu_result_ex_mem[1], 1'b0};
        be_n    = alu_result_ex_mem[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{store_data_ex_mem[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_err_q;

  always_comb begin
    case (funct3_ex_mem[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_result_ex_mem[0];
      default: misaligned = |alu_result_ex_mem[1:0];
    endcase
  end

  assign trap = misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_err_q <= 1'b0;
    else     misalign_err_q <= (state_q == StIdle) & access & trap;
  end

  assign misalign_err = misalign_err_q;
`else
  assign trap         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign capture = (state_q == StIdle) & access & ~trap;

  // Load extraction: shift the addressed lane down, then extend by size.
  assign shifted = dmem.rdata >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_val = dmem.rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    memdata_d = memdata_q;
    bus_err_d = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      StIdle: begin
        if (access) begin
          stall_raw = 1'b1;
          state_d   = trap ? StDone : StBusy;
          if (trap && !mem_write_ex_mem) memdata_d = '0;
        end
      end
      StBusy: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (dmem.ack) begin
          state_d = StDone;
          cnt_d   = '0;
          if (load_q) memdata_d = load_val;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StDone;
          cnt_d     = '0;
          bus_err_d = 1'b1;
          if (load_q) memdata_d = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      memdata_q <= '0;
      bus_err_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      load_q    <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      memdata_q <= memdata_d;
      bus_err_q <= bus_err_d;
      if (capture) begin
        addr_q   <= {alu_result_ex_mem[ADDR_W-1:2], 2'b00};
        we_q     <= mem_write_ex_mem;
        load_q   <= ~mem_write_ex_mem;
        be_q     <= be_n;
        wdata_q  <= wdata_n;
        funct3_q <= funct3_ex_mem;
        off_q    <= off_n;
      end
    end
  end

  assign dmem.req   = (state_q == StBusy);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;
  assign memdata    = memdata_q;
  assign bus_err    = bus_err_q;
  // Gated by rst so the upstream freeze releases the instant reset is applied.
  assign mem_stall  = stall_raw & ~rst;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [2:0]  f3;
  logic [31:0] alu, sd;
  logic [31:0] memdata;
  logic        stall, bus_err, mis_err;

  always #5 clk = ~clk;

  mem_access_stage_if #(.ADDR_W(32)) dmem ();

  mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_ex_mem   (rd),
    .mem_write_ex_mem  (wr),
    .funct3_ex_mem     (f3),
    .alu_result_ex_mem (alu),
    .store_data_ex_mem (sd),
    .dmem              (dmem),
    .memdata           (memdata),
    .mem_stall         (stall),
    .bus_err           (bus_err),
    .misalign_err      (mis_err)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_md = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One access: drive EX/MEM controls, play memory with ack after ack_delay BUSY cycles
  // (negative = never), and check the DONE cycle against the scoreboard.
  task automatic access_step(input string name, input logic r, input logic w,
                             input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d,
                             input int ack_delay, input logic [31:0] rdata,
                             input logic [31:0] exp_md, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input bit exp_trap);
    int          stalls = 0;
    int          reqs = 0;
    int          cyc = 0;
    int          exp_reqs;
    bit          done = 0;
    logic [31:0] got_addr = '0;
    logic        got_we = 1'b0;
    logic [3:0]  got_be = '0;
    logic [31:0] got_wdata = '0;
    logic [31:0] want;
    logic [31:0] popped;
    exp_reqs = exp_trap ? 0 : ((ack_delay < 0) ? int'(TO) : ack_delay + 1);
    want = (r && !w && !exp_trap) ? exp_md : ((r && !w) ? 32'h0 : model_md);
    exp_q.push_back(want);
    rd = r; wr = w; f3 = fn; alu = a; sd = d;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      dmem.ack = 1'b0;
      if (dmem.req) begin
        reqs++;
        if (reqs == 1) begin
          got_addr = dmem.addr; got_we = dmem.we; got_be = dmem.be; got_wdata = dmem.wdata;
        end
        if (ack_delay >= 0 && reqs == ack_delay + 1) begin
          dmem.ack = 1'b1;
          dmem.rdata = rdata;
        end
      end
      if (stall) stalls++;
      else begin
        done = 1;
        popped = exp_q.pop_front();
        check({name, "_memdata"}, memdata, popped);
        check({name, "_bus_err"}, 32'(bus_err), 32'((ack_delay < 0) && !exp_trap));
        check({name, "_misalign_err"}, 32'(mis_err), 32'(exp_trap));
        model_md = popped;
      end
    end
    if (!done) check({name, "_hang"}, 32'(0), 32'(1));
    check({name, "_stall_cycles"}, 32'(stalls), 32'(1 + exp_reqs));
    check({name, "_req_cycles"}, 32'(reqs), 32'(exp_reqs));
    if (reqs > 0) begin
      check({name, "_addr"}, got_addr, exp_addr);
      check({name, "_we"}, 32'(got_we), 32'(w));
      if (w) begin
        check({name, "_be"}, 32'(got_be), 32'(exp_be));
        check({name, "_wdata"}, got_wdata, exp_wdata);
      end
    end
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check({name, "_post_stall"}, 32'(stall), 32'(0));
    check({name, "_post_err"}, 32'({bus_err, mis_err}), 32'(0));
    check({name, "_post_memdata"}, memdata, model_md);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rd = 1'b0; wr = 1'b0; f3 = 3'b000; alu = '0; sd = '0;
    dmem.ack = 1'b0; dmem.rdata = '0;
    #2 rst = 1'b1;
    #2;
    check("rst_memdata", memdata, 32'h0);
    check("rst_req", 32'(dmem.req), 32'(0));
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_addr", dmem.addr, 32'h0);
    check("rst_be_we", 32'({dmem.be, dmem.we}), 32'(0));
    check("rst_wdata", dmem.wdata, 32'h0);
    check("rst_errs", 32'({bus_err, mis_err}), 32'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Loads
    access_step("lw",  1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 4'hF, 0, 0);
    access_step("lb",  1, 0, 3'b000, 32'h103, 0, 0, 32'h80FFFFFF, 32'hFFFFFF80, 32'h100, 4'h8, 0, 0);
    access_step("lbu", 1, 0, 3'b100, 32'h103, 0, 0, 32'h80FFFFFF, 32'h00000080, 32'h100, 4'h8, 0, 0);
    access_step("lhu", 1, 0, 3'b101, 32'h102, 0, 0, 32'h80FFFFFF, 32'h000080FF, 32'h100, 4'hC, 0, 0);
    access_step("lh_wait", 1, 0, 3'b001, 32'h102, 0, 2, 32'h80FF0000, 32'hFFFF80FF, 32'h100, 4'hC,
                0, 0);
    access_step("lbu1", 1, 0, 3'b100, 32'h101, 0, 0, 32'h0000AB00, 32'h000000AB, 32'h100, 4'h2, 0, 0);
    access_step("f3_011", 1, 0, 3'b011, 32'h104, 0, 0, 32'h13572468, 32'h13572468, 32'h104, 4'hF,
                0, 0);

    // Stores
    access_step("sb", 0, 1, 3'b000, 32'h0A1, 32'h12345678, 1, 0, 0, 32'h0A0, 4'b0010, 32'h78787878, 0);
    access_step("sh", 0, 1, 3'b001, 32'h0A2, 32'h12345678, 0, 0, 0, 32'h0A0, 4'b1100, 32'h56785678, 0);
    access_step("sw", 0, 1, 3'b010, 32'h0A4, 32'h12345678, 0, 0, 0, 32'h0A4, 4'b1111, 32'h12345678, 0);
    access_step("rw_both", 1, 1, 3'b010, 32'h0A8, 32'hA5A5A5A5, 0, 32'hFFFFFFFF, 0, 32'h0A8, 4'hF,
                32'hA5A5A5A5, 0);

    // Timeout abort, then a normal load
    access_step("lw_timeout", 1, 0, 3'b010, 32'h10C, 0, -1, 0, 32'h0, 32'h10C, 4'hF, 0, 0);
    access_step("lw_after_to", 1, 0, 3'b010, 32'h110, 0, 0, 32'h11223344, 32'h11223344, 32'h110,
                4'hF, 0, 0);

    // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
    access_step("lh_mis", 1, 0, 3'b001, 32'h101, 0, 0, 32'h12348001, 32'h0, 32'h100, 4'h3, 0, 1);
    access_step("sw_mis", 0, 1, 3'b010, 32'h0A6, 32'hCAFEBABE, 0, 0, 0, 32'h0A4, 4'hF, 32'hCAFEBABE, 1);
`else
    access_step("lh_mis", 1, 0, 3'b001, 32'h101, 0, 0, 32'h12348001, 32'hFFFF8001, 32'h100, 4'h3, 0, 0);
    access_step("sw_mis", 0, 1, 3'b010, 32'h0A6, 32'hCAFEBABE, 0, 0, 0, 32'h0A4, 4'hF, 32'hCAFEBABE, 0);
`endif

    // Stray ack while idle is ignored
    dmem.ack = 1'b1; dmem.rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    check("stray_ack_req", 32'(dmem.req), 32'(0));
    check("stray_ack_stall", 32'(stall), 32'(0));
    check("stray_ack_memdata", memdata, model_md);
    dmem.ack = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of BUSY
    rd = 1'b1; wr = 1'b0; f3 = 3'b010; alu = 32'h200;
    repeat (3) @(negedge clk);
    check("pre_rst_req", 32'(dmem.req), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(dmem.req), 32'(0));
    check("mid_rst_stall", 32'(stall), 32'(0));
    check("mid_rst_memdata", memdata, 32'h0);
    model_md = 32'h0;
    rd = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    access_step("lw_after_rst", 1, 0, 3'b010, 32'h300, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 32'h300,
                4'hF, 0, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
